router_sync_ctrl: RTL and testbench
===================================

# router_sync_ctrl

Output-port controller for the 1x3 packet router, sitting between the router FSM and the three output FIFOs. It latches the 2-bit destination address from the header byte, steers the FSM's single write enable to the selected FIFO, returns that FIFO's full flag to the FSM, and drives the per-port valid outputs. It also runs three independent read-timeout watchdogs that soft-reset a FIFO whose data has gone unread for too long.

## Interface

Parameters:
- TIMEOUT, 30, number of consecutive stalled cycles (valid and not read) before a port is soft-reset; legal range 2..255.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  synchronous reset, active-low; sampled on rising edge of clock.
- detect_add  in  1  from FSM; when high, the address is captured from data_in.
- data_in  in  2  header bits [1:0]: the destination address.
- write_enb_reg  in  1  from FSM; write strobe for the currently addressed FIFO.
- read_enb_0/1/2  in  1  read enables from the external receivers.
- empty_0/1/2  in  1  FIFO empty flags.
- full_0/1/2  in  1  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enables (bit n = FIFO n).
- fifo_full  out  1  full flag of the addressed FIFO, to FSM.
- vld_out_0/1/2  out  1  port n holds data.
- soft_reset_0/1/2  out  1  one-cycle soft-reset pulse to FIFO n (also to FSM).

## Operation

- Address register addr[1:0]: reset value 2'b11 (no port). On a rising edge with detect_add=1: addr <= data_in. Otherwise holds. Address 2'b11 is illegal and selects no port.
- write_enb (combinational): 3'b000 when write_enb_reg=0. When write_enb_reg=1: addr 00 -> 001, 01 -> 010, 10 -> 100, 11 -> 000.
- fifo_full (combinational): full_0/full_1/full_2 for addr 00/01/10; 0 for addr 11.
- vld_out_n (combinational) = ~empty_n.
- Watchdog per port n, counter cnt_n of width ceil(log2(TIMEOUT)), reset value 0:
  - A stall cycle is a cycle with vld_out_n=1 and read_enb_n=0.
  - Not a stall cycle (read_enb_n=1 or empty_n=1): cnt_n <= 0.
  - Stall cycle with cnt_n < TIMEOUT-1: cnt_n <= cnt_n+1.
  - Stall cycle with cnt_n == TIMEOUT-1: cnt_n <= 0 and soft_reset_n <= 1 for exactly one cycle.
  - soft_reset_n is registered, reset value 0, and deasserts on the following edge unconditionally.
- The three watchdogs are fully independent. Simultaneous timeouts on several ports are allowed, and each port pulses in the same cycle.
- The address register is independent of the watchdogs: a soft-reset on the addressed port does not change addr.

## Timing

- Reset (resetn=0 at a rising edge): addr=2'b11, all cnt_n=0, all soft_reset_n=0. Consequences and reset-exempt signals:
  - write_enb stays 000 while addr=11.
  - fifo_full=0 while addr=11.
  - vld_out_n is combinational from empty_n and is not affected by reset.
- Reset asserted mid-count clears every counter, with no pending pulse.
- Reset has priority over detect_add.
- Address latency: detect_add sampled at edge k makes the new addr visible to write_enb and fifo_full after edge k. If detect_add and write_enb_reg are high in the same cycle, write_enb uses the previous addr.
- write_enb, fifo_full and vld_out_n have zero latency from their inputs (combinational, no registers).
- Watchdog latency: if a port stalls continuously from edge 1, soft_reset_n is high in the cycle after edge TIMEOUT (edges 1..TIMEOUT sampled as stall).
  - A single read_enb_n=1 cycle restarts the count.
  - empty_n rising restarts the count.
- If the port is still non-empty and unread in the soft_reset_n cycle, that cycle counts as stall 1 of a new window.

## Test plan

- Reset then idle: hold resetn=0 for one edge with empty_0/1/2=1 -> write_enb=000, fifo_full=0, soft_reset_0/1/2=0, vld_out_0/1/2=0.
- Address decode: detect_add=1, data_in=2'b01 for one edge, then write_enb_reg=1 -> write_enb=010. Set full_1=1 -> fifo_full=1, and full_0=1 alone -> fifo_full=0. Repeat with 00 (expect 001) and 10 (expect 100).
- Illegal address: latch data_in=2'b11, write_enb_reg=1, full_0/1/2=1 -> write_enb=000, fifo_full=0.
- Timeout, TIMEOUT=30: empty_0=0, read_enb_0=0 for 30 edges -> soft_reset_0=1 for exactly one cycle after the 30th edge, soft_reset_1/2 stay 0. Keep stalling -> next pulse 30 edges later.
- Watchdog restart: stall port 2 for 29 edges, read_enb_2=1 for one edge, then stall 29 edges -> no soft_reset_2. Stall one more edge -> pulse.
- Concurrent timeouts: empty_0/1/2=0 with all reads low for 30 edges -> soft_reset_0/1/2 pulse together. Pulse resetn=0 after 15 stalled edges in a rerun -> no pulse until 30 further stall edges.

Source files
------------

// File: rtl/router_sync_ctrl.sv
// Output-port controller for the 1x3 router: destination address latch, FIFO
// write steering, full/valid return paths and per-port read-timeout watchdogs.
module router_sync_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        PORT0     = 2'b00,
        PORT1     = 2'b01,
        PORT2     = 2'b10,
        PORT_NONE = 2'b11
    } port_t;

    port_t          r_addr;
    logic [CW-1:0]  r_cnt [3];
    logic [2:0]     r_soft_reset;
    logic [2:0]     w_empty;
    logic [2:0]     w_read;
    logic [2:0]     w_full;
    logic [2:0]     w_stall;

    assign w_empty = {empty_2, empty_1, empty_0};
    assign w_read  = {read_enb_2, read_enb_1, read_enb_0};
    assign w_full  = {full_2, full_1, full_0};
    assign w_stall = ~w_empty & ~w_read;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr <= PORT_NONE;
        end else if (detect_add) begin
            r_addr <= port_t'(data_in);
        end
    end

    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        case (r_addr)
            PORT0:   begin write_enb = {2'b00, write_enb_reg};       fifo_full = w_full[0]; end
            PORT1:   begin write_enb = {1'b0, write_enb_reg, 1'b0};  fifo_full = w_full[1]; end
            PORT2:   begin write_enb = {write_enb_reg, 2'b00};       fifo_full = w_full[2]; end
            default: begin write_enb = '0;                           fifo_full = 1'b0;      end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

    // The pulse cycle itself restarts the window at zero, so a port that
    // stays stalled through the pulse counts that cycle as stall 1.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
            r_soft_reset <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_soft_reset[i] <= 1'b0;
                if (!w_stall[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(TIMEOUT - 1)) begin
                    r_cnt[i]        <= '0;
                    r_soft_reset[i] <= 1'b1;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign soft_reset_0 = r_soft_reset[0];
    assign soft_reset_1 = r_soft_reset[1];
    assign soft_reset_2 = r_soft_reset[2];

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Directed bench for router_sync_ctrl: decode table plus watchdog sequences.
module tb_router_sync_ctrl;

    logic       clock = 1'b0;
    logic       resetn, detect_add, write_enb_reg;
    logic [1:0] data_in;
    logic [2:0] rd, em, fu;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    router_sync_ctrl #(.TIMEOUT(30)) dut (
        .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0(rd[0]), .read_enb_1(rd[1]), .read_enb_2(rd[2]),
        .empty_0(em[0]), .empty_1(em[1]), .empty_2(em[2]),
        .full_0(fu[0]), .full_1(fu[1]), .full_2(fu[2]),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    typedef struct {
        logic [1:0] addr;
        logic       wr;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic latch_addr(input logic [1:0] a);
        detect_add = 1'b1;
        data_in    = a;
        tick();
        detect_add = 1'b0;
    endtask

    // Run n edges; soft resets must be 0 except after the last edge, where exp_last is required.
    task automatic run_cycles(input int n, input logic [2:0] exp_last, input string name);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk(name, {5'b0, soft_reset_2, soft_reset_1, soft_reset_0},
                {5'b0, (i == n) ? exp_last : 3'b000});
        end
    endtask

    initial begin
        vecs[0] = '{2'b01, 1'b1, 3'b000, 3'b111, 3'b010, 1'b0, 3'b000};
        vecs[1] = '{2'b01, 1'b1, 3'b010, 3'b111, 3'b010, 1'b1, 3'b000};
        vecs[2] = '{2'b01, 1'b1, 3'b001, 3'b111, 3'b010, 1'b0, 3'b000};
        vecs[3] = '{2'b01, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 3'b101};
        vecs[4] = '{2'b00, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
        vecs[5] = '{2'b00, 1'b1, 3'b110, 3'b110, 3'b001, 1'b0, 3'b001};
        vecs[6] = '{2'b10, 1'b1, 3'b100, 3'b000, 3'b100, 1'b1, 3'b111};
        vecs[7] = '{2'b10, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 3'b000};
        vecs[8] = '{2'b11, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[9] = '{2'b11, 1'b0, 3'b111, 3'b011, 3'b000, 1'b0, 3'b100};

        resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
        rd = 3'b000; em = 3'b111; fu = 3'b000;
        @(negedge clock);
        tick();
        chk("reset write_enb", {5'b0, write_enb}, 8'h00);
        chk("reset fifo_full", {7'b0, fifo_full}, 8'h00);
        chk("reset soft_reset", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 8'h00);
        chk("reset vld_out", {5'b0, vld_out_2, vld_out_1, vld_out_0}, 8'h00);
        write_enb_reg = 1'b1; fu = 3'b111; #1;
        chk("reset addr none", {4'b0, fifo_full, write_enb}, 8'h00);
        resetn = 1'b1;
        write_enb_reg = 1'b0; fu = 3'b000;

        for (int i = 0; i < 10; i++) begin
            write_enb_reg = 1'b0;
            latch_addr(vecs[i].addr);
            write_enb_reg = vecs[i].wr;
            fu = vecs[i].full;
            em = vecs[i].empty;
            #1;
            chk($sformatf("vec%0d write_enb", i), {5'b0, write_enb}, {5'b0, vecs[i].exp_we});
            chk($sformatf("vec%0d fifo_full", i), {7'b0, fifo_full}, {7'b0, vecs[i].exp_ff});
            chk($sformatf("vec%0d vld_out", i), {5'b0, vld_out_2, vld_out_1, vld_out_0},
                {5'b0, vecs[i].exp_vld});
        end

        // detect_add and write_enb_reg together: write uses the old address
        em = 3'b111; fu = 3'b000; write_enb_reg = 1'b0;
        latch_addr(2'b01);
        detect_add = 1'b1; data_in = 2'b10; write_enb_reg = 1'b1; #1;
        chk("same-cycle old addr", {5'b0, write_enb}, 8'h02);
        tick();
        detect_add = 1'b0; #1;
        chk("same-cycle new addr", {5'b0, write_enb}, 8'h04);

        // reset beats detect_add
        resetn = 1'b0; detect_add = 1'b1; data_in = 2'b00;
        tick();
        resetn = 1'b1; detect_add = 1'b0; #1;
        chk("reset priority", {5'b0, write_enb}, 8'h00);

        // port 0 timeout, addressed port keeps its address through the pulse
        write_enb_reg = 1'b1;
        latch_addr(2'b00);
        em = 3'b110;
        run_cycles(30, 3'b001, "p0 first timeout");
        run_cycles(30, 3'b001, "p0 second timeout");
        #1;
        chk("addr survives soft reset", {5'b0, write_enb}, 8'h01);
        write_enb_reg = 1'b0;

        // port 2 restart by a single read
        em = 3'b111; tick();
        em = 3'b011;
        run_cycles(29, 3'b000, "p2 pre-read");
        rd = 3'b100;
        run_cycles(1, 3'b000, "p2 read");
        rd = 3'b000;
        run_cycles(29, 3'b000, "p2 post-read");
        run_cycles(1, 3'b100, "p2 timeout");

        // concurrent timeouts
        em = 3'b111; tick();
        em = 3'b000;
        run_cycles(30, 3'b111, "all timeout");

        // reset mid-count
        em = 3'b111; tick();
        em = 3'b000;
        run_cycles(15, 3'b000, "pre-reset stall");
        resetn = 1'b0;
        run_cycles(1, 3'b000, "reset edge");
        resetn = 1'b1;
        run_cycles(29, 3'b000, "post-reset stall");
        run_cycles(1, 3'b111, "post-reset timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
